// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS registers of DATA_WIDTH bits,
// optional read-only status registers, byte strobes, SLVERR on
// out-of-range indices and a one-cycle write pulse per committed RW write.
module axi_lite_regfile #(
  parameter int                   ADDR_WIDTH = 12,
  parameter int                   DATA_WIDTH = 32,  // 32 or 64
  parameter int                   NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                  ap_clk,
  input  logic                                  ap_rst,
  input  logic [ADDR_WIDTH-1:0]                 s_axi_awaddr,
  input  logic                                  s_axi_awvalid,
  output logic                                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                 s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]               s_axi_wstrb,
  input  logic                                  s_axi_wvalid,
  output logic                                  s_axi_wready,
  output logic [1:0]                            s_axi_bresp,
  output logic                                  s_axi_bvalid,
  input  logic                                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]                 s_axi_araddr,
  input  logic                                  s_axi_arvalid,
  output logic                                  s_axi_arready,
  output logic [DATA_WIDTH-1:0]                 s_axi_rdata,
  output logic [1:0]                            s_axi_rresp,
  output logic                                  s_axi_rvalid,
  input  logic                                  s_axi_rready,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   reg_out,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   reg_in,
  output logic [NUM_REGS-1:0]                   reg_wr_pulse
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    WR_IDLE = 3'd0, WR_DATA = 3'd1, WR_RESP = 3'd2, WR_RST = 3'd3, WR_ADDR = 3'd4
  } wr_state_e;
  typedef enum logic [1:0] {RD_RST = 2'd0, RD_IDLE = 2'd1, RD_DATA = 2'd2} rd_state_e;

  wr_state_e wr_q, wr_d;
  rd_state_e rd_q, rd_d;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q;
  logic [NUM_REGS-1:0]                 pulse_q;
  logic [IDX_W-1:0]                    awidx_q;
  logic [DATA_WIDTH-1:0]               wdata_q;
  logic [STRB_W-1:0]                   wstrb_q;
  logic [1:0]                          bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]               rdata_q;

  logic [IDX_W-1:0]      aw_idx, ar_idx, c_idx;
  logic [DATA_WIDTH-1:0] c_data, rd_val;
  logic [STRB_W-1:0]     c_strb;
  logic                  commit, aw_cap, w_cap, ar_hs;
  logic                  wr_in_range, rd_in_range;
  logic [NUM_REGS-1:0]   wr_hit;
  logic                  unused_lsb;

  // Sub-word address bits never select anything.
  assign unused_lsb = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};
  assign aw_idx     = s_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign ar_idx     = s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

  // Write FSM next state / handshakes; also selects the beat being committed.
  always_comb begin
    wr_d          = wr_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    commit        = 1'b0;
    aw_cap        = 1'b0;
    w_cap         = 1'b0;
    c_idx         = awidx_q;
    c_data        = wdata_q;
    c_strb        = wstrb_q;
    unique case (wr_q)
      WR_RST: wr_d = WR_IDLE;
      WR_IDLE: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        if (s_axi_awvalid && s_axi_wvalid) begin
          commit = 1'b1;
          c_idx  = aw_idx;
          c_data = s_axi_wdata;
          c_strb = s_axi_wstrb;
          wr_d   = WR_RESP;
        end else if (s_axi_awvalid) begin
          aw_cap = 1'b1;
          wr_d   = WR_DATA;
        end else if (s_axi_wvalid) begin
          w_cap = 1'b1;
          wr_d  = WR_ADDR;
        end
      end
      WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          commit = 1'b1;
          c_data = s_axi_wdata;
          c_strb = s_axi_wstrb;
          wr_d   = WR_RESP;
        end
      end
      WR_ADDR: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) begin
          commit = 1'b1;
          c_idx  = aw_idx;
          wr_d   = WR_RESP;
        end
      end
      WR_RESP: if (s_axi_bready) wr_d = WR_IDLE;
      default: wr_d = WR_IDLE;
    endcase
  end

  // Decode which register (if any) a committing write lands on; RO slots never hit.
  always_comb begin
    wr_in_range = (32'(c_idx) < NUM_REGS);
    wr_hit      = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_hit[i] = commit && (32'(c_idx) == i) && !RO_MASK[i];
  end

  // Write state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) wr_q <= WR_RST;
    else        wr_q <= wr_d;
  end

  // Write datapath: beat capture, strobed register update, response and pulse.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      reg_q   <= {NUM_REGS{RESET_VAL}};
      pulse_q <= '0;
      awidx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      pulse_q <= '0;
      if (aw_cap) awidx_q <= aw_idx;
      if (w_cap) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (commit) bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          pulse_q[i] <= 1'b1;
          for (int k = 0; k < STRB_W; k++)
            if (c_strb[k]) reg_q[i][8*k +: 8] <= c_data[8*k +: 8];
        end
      end
    end
  end

  // Read FSM next state / handshake.
  always_comb begin
    rd_d          = rd_q;
    s_axi_arready = 1'b0;
    ar_hs         = 1'b0;
    unique case (rd_q)
      RD_RST:  rd_d = RD_IDLE;
      RD_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          ar_hs = 1'b1;
          rd_d  = RD_DATA;
        end
      end
      RD_DATA: if (s_axi_rready) rd_d = RD_IDLE;
      default: rd_d = RD_IDLE;
    endcase
  end

  // Read mux: RO slots return live status, out-of-range returns zero.
  always_comb begin
    rd_in_range = (32'(ar_idx) < NUM_REGS);
    rd_val      = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(ar_idx) == i) rd_val = RO_MASK[i] ? reg_in[i] : reg_q[i];
  end

  // Read state and response registers; sampling reg_q here yields pre-write data on a same-cycle commit.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rd_q    <= RD_RST;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      rd_q <= rd_d;
      if (ar_hs) begin
        rdata_q <= rd_val;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi_bvalid = (wr_q == WR_RESP);
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = (rd_q == RD_DATA);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign reg_out      = reg_q;
  assign reg_wr_pulse = pulse_q;
endmodule
